// File: rtl/btn_pkg.sv
// Shared types and constants for the push-button cursor front end:
// command codes, button indices and the fixed arbitration order.
package btn_pkg;

    typedef enum logic [2:0] {
        NONE  = 3'd0,
        SEL   = 3'd1,
        UP    = 3'd2,
        DOWN  = 3'd3,
        LEFT  = 3'd4,
        RIGHT = 3'd5
    } cmd_e;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_ISSUE = 1'b1
    } state_e;

    localparam int NBTN = 5;

    localparam logic [2:0] IDX_C = 3'd0;
    localparam logic [2:0] IDX_U = 3'd1;
    localparam logic [2:0] IDX_D = 3'd2;
    localparam logic [2:0] IDX_L = 3'd3;
    localparam logic [2:0] IDX_R = 3'd4;

    // Highest priority first.
    localparam logic [2:0] PRIO [NBTN] = '{IDX_C, IDX_U, IDX_D, IDX_L, IDX_R};

    function automatic cmd_e cmd_of_idx(input logic [2:0] idx);
        cmd_e c;
        case (idx)
            IDX_C:   c = SEL;
            IDX_U:   c = UP;
            IDX_D:   c = DOWN;
            IDX_L:   c = LEFT;
            IDX_R:   c = RIGHT;
            default: c = NONE;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// One push-button channel: 2-flop synchronizer, persistence counter,
// debounced stable level and a one-cycle pulse on its rising edge.
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic rise
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync1;
    logic          sync2;
    logic          stable;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1  <= 1'b0;
            sync2  <= 1'b0;
            stable <= 1'b0;
            cnt    <= '0;
            rise   <= 1'b0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
            rise  <= 1'b0;
            if (sync2 != stable) begin
                // The count about to reach DEBOUNCE_CYCLES flips the level instead.
                if (cnt == CNT_LAST) begin
                    stable <= sync2;
                    cnt    <= '0;
                    rise   <= sync2;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end else begin
                cnt <= '0;
            end
        end
    end

endmodule

// File: rtl/btn_cursor_ctrl.sv
// Button front end: five debounced channels, fixed-priority arbiter, a
// valid/ready command FSM and the grid cursor register. Define
// CURSOR_WRAP_EN to make moves wrap at the grid edges instead of clamping.
module btn_cursor_ctrl
    import btn_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int COLS            = 4,
    parameter int ROWS            = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    bC,
    input  logic                    bL,
    input  logic                    bU,
    input  logic                    bR,
    input  logic                    bD,
    input  logic                    cmd_ready,
    output logic                    cmd_valid,
    output logic [2:0]              cmd,
    output logic [$clog2(COLS)-1:0] cur_x,
    output logic [$clog2(ROWS)-1:0] cur_y,
    output logic                    sel_pulse
);

    // Handshake: cmd is held stable while cmd_valid is high and is consumed
    // on any edge where cmd_valid && cmd_ready; cmd_ready is ignored otherwise.

    localparam int XW = $clog2(COLS);
    localparam int YW = $clog2(ROWS);
    localparam logic [XW:0] X_MAX = (XW + 1)'(COLS - 1);
    localparam logic [YW:0] Y_MAX = (YW + 1)'(ROWS - 1);

    logic [NBTN-1:0] raw;
    logic [NBTN-1:0] rise;
    logic [NBTN-1:0] pend;
    logic [NBTN-1:0] pend_nxt;

    assign raw[IDX_C] = bC;
    assign raw[IDX_U] = bU;
    assign raw[IDX_D] = bD;
    assign raw[IDX_L] = bL;
    assign raw[IDX_R] = bR;

    for (genvar b = 0; b < NBTN; b++) begin : g_btn
        btn_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_deb (
            .clk  (clk),
            .rst  (rst),
            .raw  (raw[b]),
            .rise (rise[b])
        );
    end

    // Fixed-priority pick: scan lowest priority first so the highest wins.
    logic       grant_vld;
    logic [2:0] grant_idx;

    always_comb begin
        grant_vld = 1'b0;
        grant_idx = IDX_C;
        for (int i = NBTN - 1; i >= 0; i--) begin
            if (pend[PRIO[i]]) begin
                grant_vld = 1'b1;
                grant_idx = PRIO[i];
            end
        end
    end

    state_e state;
    state_e state_nxt;
    cmd_e   cmd_q;
    logic   load;
    logic   accept;

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (grant_vld) state_nxt = ST_ISSUE;
            ST_ISSUE: if (cmd_ready) state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        cmd_valid = (state == ST_ISSUE);
        load      = (state == ST_IDLE) && grant_vld;
        accept    = (state == ST_ISSUE) && cmd_ready;
    end

    assign cmd = cmd_q;

    // A new rising edge beats the arbiter's clear of the same bit.
    always_comb begin
        pend_nxt = pend;
        if (load) pend_nxt[grant_idx] = 1'b0;
        pend_nxt = pend_nxt | rise;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pend      <= '0;
            cmd_q     <= NONE;
            sel_pulse <= 1'b0;
        end else begin
            pend      <= pend_nxt;
            sel_pulse <= accept && (cmd_q == SEL);
            if (load)        cmd_q <= cmd_of_idx(grant_idx);
            else if (accept) cmd_q <= NONE;
        end
    end

    // Edge tests are done one bit wider so no move can wrap via arithmetic.
    logic [XW-1:0] x_nxt;
    logic [YW-1:0] y_nxt;

    always_comb begin
        x_nxt = cur_x;
        y_nxt = cur_y;
        case (cmd_q)
            LEFT: begin
                if ({1'b0, cur_x} == '0) begin
`ifdef CURSOR_WRAP_EN
                    x_nxt = X_MAX[XW-1:0];
`else
                    x_nxt = cur_x;
`endif
                end else begin
                    x_nxt = cur_x - 1'b1;
                end
            end
            RIGHT: begin
                if ({1'b0, cur_x} >= X_MAX) begin
`ifdef CURSOR_WRAP_EN
                    x_nxt = '0;
`else
                    x_nxt = cur_x;
`endif
                end else begin
                    x_nxt = cur_x + 1'b1;
                end
            end
            UP: begin
                if ({1'b0, cur_y} == '0) begin
`ifdef CURSOR_WRAP_EN
                    y_nxt = Y_MAX[YW-1:0];
`else
                    y_nxt = cur_y;
`endif
                end else begin
                    y_nxt = cur_y - 1'b1;
                end
            end
            DOWN: begin
                if ({1'b0, cur_y} >= Y_MAX) begin
`ifdef CURSOR_WRAP_EN
                    y_nxt = '0;
`else
                    y_nxt = cur_y;
`endif
                end else begin
                    y_nxt = cur_y + 1'b1;
                end
            end
            default: begin
                x_nxt = cur_x;
                y_nxt = cur_y;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cur_x <= '0;
            cur_y <= '0;
        end else if (accept) begin
            cur_x <= x_nxt;
            cur_y <= y_nxt;
        end
    end

endmodule
